// File: rtl/hdcpu_ctl.sv
`default_nettype none
// ============================================================================
// Module   : hdcpu_ctl
// Purpose  : Hardwired control unit for the teaching CPU. It generates its own
//            W1..W3 beats on the falling edge of T3, runs the front-panel
//            memory/register sequences and the stop/resume handshake, and
//            decodes IR[7:4] into the datapath control vector.
// Options  : HDCTL_EXT_OPS_EN - adds the OUT, XOR and OR opcodes (1010..1100).
//            When it is undefined those opcodes fetch only, like NOP.
// Revision : 1.0 - initial release
// ============================================================================
module hdcpu_ctl #(
  parameter int REG_CNT = 4,
  parameter int RA_W    = $clog2(REG_CNT)
) (
  input  logic              T3,
  input  logic              CLR,
  input  logic [2:0]        SW,
  input  logic              QD,
  input  logic [3:0]        IR,
  input  logic              C,
  input  logic              Z,
  output logic [2:0]        W,
  output logic              ST0,
  output logic [2*RA_W-1:0] SEL,
  output logic [3:0]        S,
  output logic              LDC,
  output logic              LDZ,
  output logic              CIN,
  output logic              M,
  output logic              ABUS,
  output logic              SBUS,
  output logic              MBUS,
  output logic              DRW,
  output logic              PCINC,
  output logic              LPC,
  output logic              LAR,
  output logic              PCADD,
  output logic              ARINC,
  output logic              SELCTL,
  output logic              MEMW,
  output logic              LIR,
  output logic              STOP,
  output logic              SHORT,
  output logic              LONG
);

  // One-hot beat encodings {W3,W2,W1}
  localparam logic [2:0] c_W1 = 3'b001;
  localparam logic [2:0] c_W2 = 3'b010;
  localparam logic [2:0] c_W3 = 3'b100;

  // Panel modes
  localparam logic [2:0] c_SW_RUN = 3'b000;
  localparam logic [2:0] c_SW_MWR = 3'b001;
  localparam logic [2:0] c_SW_MRD = 3'b010;
  localparam logic [2:0] c_SW_RRD = 3'b011;
  localparam logic [2:0] c_SW_RWR = 3'b100;

  // Opcodes
  localparam logic [3:0] c_OP_NOP = 4'b0000;
  localparam logic [3:0] c_OP_ADD = 4'b0001;
  localparam logic [3:0] c_OP_SUB = 4'b0010;
  localparam logic [3:0] c_OP_AND = 4'b0011;
  localparam logic [3:0] c_OP_INC = 4'b0100;
  localparam logic [3:0] c_OP_LD  = 4'b0101;
  localparam logic [3:0] c_OP_ST  = 4'b0110;
  localparam logic [3:0] c_OP_JC  = 4'b0111;
  localparam logic [3:0] c_OP_JZ  = 4'b1000;
  localparam logic [3:0] c_OP_JMP = 4'b1001;
  localparam logic [3:0] c_OP_STP = 4'b1110;
`ifdef HDCTL_EXT_OPS_EN
  localparam logic [3:0] c_OP_OUT = 4'b1010;
  localparam logic [3:0] c_OP_XOR = 4'b1011;
  localparam logic [3:0] c_OP_OR  = 4'b1100;
`endif

  // Register index steps; both wrap naturally at REG_CNT (a power of two)
  localparam logic [RA_W-1:0] c_RIDX_ONE = RA_W'(1);
  localparam logic [RA_W-1:0] c_RIDX_TWO = RA_W'(2);

  logic [2:0]      r_w;
  logic            r_st0;
  logic [RA_W-1:0] r_ridx;
  logic            r_halt;
  logic [2:0]      r_swq;

  logic [2:0]      w_w_next;
  logic            w_set_st0;
  logic [RA_W-1:0] w_ridx_next;
  logic            w_f1;
  logic            w_f2;

  assign W   = r_w;
  assign ST0 = r_st0;

  // Decode mode, phase, beat and opcode into the control vector
  always_comb begin
    LDC = 1'b0;  LDZ = 1'b0;   CIN = 1'b0;   M = 1'b0;      ABUS = 1'b0;
    SBUS = 1'b0; MBUS = 1'b0;  DRW = 1'b0;   PCINC = 1'b0;  LPC = 1'b0;
    LAR = 1'b0;  PCADD = 1'b0; ARINC = 1'b0; SELCTL = 1'b0; MEMW = 1'b0;
    LIR = 1'b0;  STOP = 1'b0;  SHORT = 1'b0; LONG = 1'b0;
    SEL = '0;
    S = 4'b0000;
    w_set_st0 = 1'b0;
    w_ridx_next = r_ridx;
    w_f1 = 1'b0;
    w_f2 = 1'b0;
    if (r_halt) begin
      STOP = 1'b1;
    end else begin
      case (r_swq)
        c_SW_MWR: begin
          if (r_w == c_W1) begin
            SBUS = 1'b1; STOP = 1'b1; SHORT = 1'b1; SELCTL = 1'b1;
            if (!r_st0) begin
              LAR = 1'b1;
              w_set_st0 = 1'b1;
            end else begin
              MEMW = 1'b1; ARINC = 1'b1;
            end
          end
        end
        c_SW_MRD: begin
          if (r_w == c_W1) begin
            STOP = 1'b1; SHORT = 1'b1; SELCTL = 1'b1;
            if (!r_st0) begin
              LAR = 1'b1; SBUS = 1'b1;
              w_set_st0 = 1'b1;
            end else begin
              MBUS = 1'b1; ARINC = 1'b1;
            end
          end
        end
        c_SW_RRD: begin
          if (r_w == c_W1) begin
            SELCTL = 1'b1; STOP = 1'b1; SHORT = 1'b1;
            SEL = {r_ridx, r_ridx + c_RIDX_ONE};
            w_ridx_next = r_ridx + c_RIDX_TWO;
          end
        end
        c_SW_RWR: begin
          if (r_w == c_W1) begin
            SBUS = 1'b1; SELCTL = 1'b1; DRW = 1'b1; STOP = 1'b1; SHORT = 1'b1;
            SEL = {r_ridx, r_ridx};
            w_ridx_next = r_ridx + c_RIDX_ONE;
          end
        end
        c_SW_RUN: begin
          if (!r_st0) begin
            // Load the start address from the switches, then halt
            if (r_w == c_W1) begin
              LPC = 1'b1; SBUS = 1'b1; SHORT = 1'b1; STOP = 1'b1;
              w_set_st0 = 1'b1;
            end
          end else begin
            case (IR)
              c_OP_NOP: w_f1 = 1'b1;
              c_OP_ADD: begin
                if (r_w == c_W1) begin
                  S = 4'b1001; CIN = 1'b1; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1; LDC = 1'b1;
                end
                w_f1 = 1'b1;
              end
              c_OP_SUB: begin
                if (r_w == c_W1) begin
                  S = 4'b0110; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1; LDC = 1'b1;
                end
                w_f1 = 1'b1;
              end
              c_OP_AND: begin
                if (r_w == c_W1) begin
                  M = 1'b1; S = 4'b1011; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1;
                end
                w_f1 = 1'b1;
              end
              c_OP_INC: begin
                if (r_w == c_W1) begin
                  S = 4'b0000; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1; LDC = 1'b1;
                end
                w_f1 = 1'b1;
              end
              c_OP_LD: begin
                if (r_w == c_W1) begin
                  M = 1'b1; S = 4'b1010; ABUS = 1'b1; LAR = 1'b1;
                end else if (r_w == c_W2) begin
                  DRW = 1'b1; MBUS = 1'b1;
                end
                w_f2 = 1'b1;
              end
              c_OP_ST: begin
                if (r_w == c_W1) begin
                  M = 1'b1; S = 4'b1111; ABUS = 1'b1; LAR = 1'b1;
                end else if (r_w == c_W2) begin
                  M = 1'b1; S = 4'b1010; ABUS = 1'b1; MEMW = 1'b1;
                end
                w_f2 = 1'b1;
              end
              c_OP_JC, c_OP_JZ: begin
                // Taken branches spend W1 on the PC add and fetch in W2
                if ((IR == c_OP_JC) ? C : Z) begin
                  if (r_w == c_W1) PCADD = 1'b1;
                  w_f2 = 1'b1;
                end else begin
                  w_f1 = 1'b1;
                end
              end
              c_OP_JMP: begin
                if (r_w == c_W1) begin
                  M = 1'b1; S = 4'b1111; ABUS = 1'b1; LPC = 1'b1;
                end
                w_f2 = 1'b1;
              end
              c_OP_STP: begin
                if (r_w == c_W1) STOP = 1'b1;
              end
`ifdef HDCTL_EXT_OPS_EN
              c_OP_OUT: begin
                if (r_w == c_W1) begin
                  M = 1'b1; S = 4'b1010; ABUS = 1'b1;
                end
                w_f1 = 1'b1;
              end
              c_OP_XOR: begin
                if (r_w == c_W1) begin
                  M = 1'b1; S = 4'b0110; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1;
                end
                w_f1 = 1'b1;
              end
              c_OP_OR: begin
                if (r_w == c_W1) begin
                  M = 1'b1; S = 4'b1110; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1;
                end
                w_f1 = 1'b1;
              end
`endif
              default: w_f1 = 1'b1;
            endcase
            // Fetch of the next instruction: in W1 (short cycle) or in W2
            if (w_f1 && (r_w == c_W1)) begin
              LIR = 1'b1; PCINC = 1'b1; SHORT = 1'b1;
            end
            if (w_f2 && (r_w == c_W2)) begin
              LIR = 1'b1; PCINC = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Beat sequencing: SHORT repeats W1, LONG extends W2 into W3
  always_comb begin
    case (r_w)
      c_W1:    w_w_next = SHORT ? c_W1 : c_W2;
      c_W2:    w_w_next = LONG ? c_W3 : c_W1;
      default: w_w_next = c_W1;
    endcase
  end

  // State update on the falling T3 edge; a mode change overrides everything
  always_ff @(negedge T3 or posedge CLR) begin
    if (CLR) begin
      r_w    <= c_W1;
      r_st0  <= 1'b0;
      r_ridx <= '0;
      r_halt <= 1'b0;
      r_swq  <= c_SW_RUN;
    end else if (SW != r_swq) begin
      r_swq  <= SW;
      r_st0  <= 1'b0;
      r_ridx <= '0;
      r_w    <= c_W1;
    end else if (r_halt) begin
      if (QD) r_halt <= 1'b0;
    end else begin
      r_w    <= w_w_next;
      r_ridx <= w_ridx_next;
      if (STOP) r_halt <= 1'b1;
      if (w_set_st0) r_st0 <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdcpu_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdcpu_ctl
// Purpose  : Self-checking bench for hdcpu_ctl: hand-derived vector table,
//            multi-cycle corner sequences and a randomized run against a
//            behavioural model of the control rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdcpu_ctl;

  localparam int N  = 4;
  localparam int AW = 2;

  // Control bit positions in {LDC,...,LONG}
  localparam logic [18:0] B_LDC    = 19'd1 << 18;
  localparam logic [18:0] B_LDZ    = 19'd1 << 17;
  localparam logic [18:0] B_CIN    = 19'd1 << 16;
  localparam logic [18:0] B_M      = 19'd1 << 15;
  localparam logic [18:0] B_ABUS   = 19'd1 << 14;
  localparam logic [18:0] B_SBUS   = 19'd1 << 13;
  localparam logic [18:0] B_MBUS   = 19'd1 << 12;
  localparam logic [18:0] B_DRW    = 19'd1 << 11;
  localparam logic [18:0] B_PCINC  = 19'd1 << 10;
  localparam logic [18:0] B_LPC    = 19'd1 << 9;
  localparam logic [18:0] B_LAR    = 19'd1 << 8;
  localparam logic [18:0] B_PCADD  = 19'd1 << 7;
  localparam logic [18:0] B_ARINC  = 19'd1 << 6;
  localparam logic [18:0] B_SELCTL = 19'd1 << 5;
  localparam logic [18:0] B_MEMW   = 19'd1 << 4;
  localparam logic [18:0] B_LIR    = 19'd1 << 3;
  localparam logic [18:0] B_STOP   = 19'd1 << 2;
  localparam logic [18:0] B_SHORT  = 19'd1 << 1;
  localparam logic [18:0] B_LONG   = 19'd1 << 0;
  localparam logic [18:0] F1 = B_LIR | B_PCINC | B_SHORT;
  localparam logic [18:0] F2 = B_LIR | B_PCINC;
  localparam logic [18:0] RWR = B_SBUS | B_SELCTL | B_DRW | B_STOP | B_SHORT;

  logic T3 = 1'b1;
  logic CLR;
  logic [2:0] SW;
  logic QD;
  logic [3:0] IR;
  logic C, Z;
  logic [2:0] W;
  logic ST0;
  logic [2*AW-1:0] SEL;
  logic [3:0] S;
  logic LDC, LDZ, CIN, M, ABUS, SBUS, MBUS, DRW, PCINC, LPC, LAR, PCADD,
        ARINC, SELCTL, MEMW, LIR, STOP, SHORT, LONG;

  hdcpu_ctl #(.REG_CNT(N)) dut (
    .T3(T3), .CLR(CLR), .SW(SW), .QD(QD), .IR(IR), .C(C), .Z(Z),
    .W(W), .ST0(ST0), .SEL(SEL), .S(S),
    .LDC(LDC), .LDZ(LDZ), .CIN(CIN), .M(M), .ABUS(ABUS), .SBUS(SBUS),
    .MBUS(MBUS), .DRW(DRW), .PCINC(PCINC), .LPC(LPC), .LAR(LAR),
    .PCADD(PCADD), .ARINC(ARINC), .SELCTL(SELCTL), .MEMW(MEMW), .LIR(LIR),
    .STOP(STOP), .SHORT(SHORT), .LONG(LONG)
  );

  always #5 T3 = ~T3;

  wire [18:0] act_fl = {LDC, LDZ, CIN, M, ABUS, SBUS, MBUS, DRW, PCINC, LPC,
                        LAR, PCADD, ARINC, SELCTL, MEMW, LIR, STOP, SHORT, LONG};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [2:0] ew, input logic est0,
                       input logic [3:0] esel, input logic [3:0] es, input logic [18:0] efl);
    logic [30:0] a, e;
    a = {W, ST0, SEL, S, act_fl};
    e = {ew, est0, esel, es, efl};
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got W=%b ST0=%b SEL=%b S=%b ctl=%b, want W=%b ST0=%b SEL=%b S=%b ctl=%b",
               nm, W, ST0, SEL, S, act_fl, ew, est0, esel, es, efl);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [18:0] fl;
    logic [3:0]  s;
    logic [3:0]  sel;
    bit          set_st0;
    int          ridx_add;
  } act_t;

  int m_beat, m_ridx, m_swq;
  bit m_st0, m_halt;

  function automatic logic [2:0] beat_w(int b);
    return 3'(1 << (b - 1));
  endfunction

  task automatic model_reset();
    m_beat = 1; m_ridx = 0; m_swq = 0; m_st0 = 0; m_halt = 0;
  endtask

  function automatic act_t model_act(int swq, bit st0, int ridx, int beat,
                                     logic [3:0] ir, bit c, bit z, bit halt);
    act_t a;
    logic [18:0] w1, w2;
    logic [3:0] s1, s2;
    int fk;
    logic [AW-1:0] hi, lo;
    a.fl = '0; a.s = '0; a.sel = '0; a.set_st0 = 0; a.ridx_add = 0;
    if (halt) begin
      a.fl = B_STOP;
      return a;
    end
    if (swq == 0 && st0) begin
      // Per-opcode W1 actions, W2 actions and fetch style (0 none, 1=F1, 2=F2)
      w1 = '0; w2 = '0; s1 = '0; s2 = '0; fk = 1;
      case (int'(ir))
        1: begin w1 = B_CIN | B_ABUS | B_DRW | B_LDZ | B_LDC; s1 = 4'b1001; end
        2: begin w1 = B_ABUS | B_DRW | B_LDZ | B_LDC; s1 = 4'b0110; end
        3: begin w1 = B_M | B_ABUS | B_DRW | B_LDZ; s1 = 4'b1011; end
        4: begin w1 = B_ABUS | B_DRW | B_LDZ | B_LDC; s1 = 4'b0000; end
        5: begin w1 = B_M | B_ABUS | B_LAR; s1 = 4'b1010; w2 = B_DRW | B_MBUS; fk = 2; end
        6: begin w1 = B_M | B_ABUS | B_LAR; s1 = 4'b1111;
                 w2 = B_M | B_ABUS | B_MEMW; s2 = 4'b1010; fk = 2; end
        7: if (c) begin w1 = B_PCADD; fk = 2; end
        8: if (z) begin w1 = B_PCADD; fk = 2; end
        9: begin w1 = B_M | B_ABUS | B_LPC; s1 = 4'b1111; fk = 2; end
        14: begin w1 = B_STOP; fk = 0; end
`ifdef HDCTL_EXT_OPS_EN
        10: begin w1 = B_M | B_ABUS; s1 = 4'b1010; end
        11: begin w1 = B_M | B_ABUS | B_DRW | B_LDZ; s1 = 4'b0110; end
        12: begin w1 = B_M | B_ABUS | B_DRW | B_LDZ; s1 = 4'b1110; end
`endif
        default: ;
      endcase
      if (beat == 1) begin a.fl = w1 | ((fk == 1) ? F1 : '0); a.s = s1; end
      if (beat == 2) begin a.fl = w2 | ((fk == 2) ? F2 : '0); a.s = s2; end
      return a;
    end
    if (beat != 1) return a;
    hi = AW'(ridx);
    case (swq)
      0: begin a.fl = B_LPC | B_SBUS | B_SHORT | B_STOP; a.set_st0 = 1; end
      1: begin a.fl = B_SBUS | B_STOP | B_SHORT | B_SELCTL | (st0 ? (B_MEMW | B_ARINC) : B_LAR);
               a.set_st0 = 1; end
      2: begin a.fl = B_STOP | B_SHORT | B_SELCTL | (st0 ? (B_MBUS | B_ARINC) : (B_LAR | B_SBUS));
               a.set_st0 = 1; end
      3: begin a.fl = B_SELCTL | B_STOP | B_SHORT; lo = AW'((ridx + 1) % N);
               a.sel = {hi, lo}; a.ridx_add = 2; end
      4: begin a.fl = RWR; a.sel = {hi, hi}; a.ridx_add = 1; end
      default: ;
    endcase
    return a;
  endfunction

  task automatic model_next(input logic [2:0] sw, input logic qd, input act_t a);
    if (int'(sw) != m_swq) begin
      m_swq = int'(sw); m_st0 = 0; m_ridx = 0; m_beat = 1;
    end else if (m_halt) begin
      if (qd) m_halt = 0;
    end else begin
      if (m_beat == 1)      m_beat = ((a.fl & B_SHORT) != 0) ? 1 : 2;
      else if (m_beat == 2) m_beat = ((a.fl & B_LONG) != 0) ? 3 : 1;
      else                  m_beat = 1;
      if ((a.fl & B_STOP) != 0) m_halt = 1;
      if (a.set_st0) m_st0 = 1;
      m_ridx = (m_ridx + a.ridx_add) % N;
    end
  endtask

  // One beat: drive after the falling edge, check mid-beat, advance the model
  task automatic rstep(input logic [2:0] sw, input logic qd, input logic [3:0] ir,
                       input logic c, input logic z, input bit pulse_clr, input string nm);
    act_t a;
    SW = sw; QD = qd; IR = ir; C = c; Z = z;
    @(posedge T3); #1;
    a = model_act(m_swq, m_st0, m_ridx, m_beat, ir, c, z, m_halt);
    check(nm, beat_w(m_beat), m_st0, a.sel, a.s, a.fl);
    if (pulse_clr) begin
      CLR = 1'b1; #1;
      model_reset();
      a = model_act(m_swq, m_st0, m_ridx, m_beat, ir, c, z, m_halt);
      check("clr_mid_rand", beat_w(m_beat), m_st0, a.sel, a.s, a.fl);
      CLR = 1'b0; #1;
    end
    model_next(sw, qd, a);
    @(negedge T3); #1;
  endtask

  task automatic do_reset();
    CLR = 1'b1; SW = 3'b000; QD = 1'b0; IR = 4'h0; C = 1'b0; Z = 1'b0;
    #1;
    model_reset();
    check("reset", 3'b001, 1'b0, 4'b0000, 4'b0000, B_LPC | B_SBUS | B_SHORT | B_STOP);
    @(negedge T3); #1;
    CLR = 1'b0;
  endtask

  // ---------------- hand-derived vector table ----------------
  typedef struct {
    logic [2:0]  sw;
    logic        qd;
    logic [3:0]  ir;
    logic        c;
    logic [2:0]  w;
    logic        st0;
    logic [3:0]  sel;
    logic [3:0]  s;
    logic [18:0] fl;
  } vec_t;

  function automatic vec_t mk(logic [2:0] sw, logic qd, logic [3:0] ir, logic c,
                              logic [2:0] w, logic st0, logic [3:0] sel,
                              logic [3:0] s, logic [18:0] fl);
    vec_t v;
    v.sw = sw; v.qd = qd; v.ir = ir; v.c = c; v.w = w; v.st0 = st0;
    v.sel = sel; v.s = s; v.fl = fl;
    return v;
  endfunction

  vec_t tbl[$];
  logic [2:0] cur_sw;

  initial begin
    CLR = 1'b1; SW = 3'b000; QD = 1'b0; IR = 4'h0; C = 1'b0; Z = 1'b0;

    tbl.push_back(mk(3'd0, 0, 4'h0, 0, 3'b001, 0, 4'h0, 4'h0, B_LPC | B_SBUS | B_SHORT | B_STOP));
    tbl.push_back(mk(3'd0, 0, 4'h5, 0, 3'b001, 1, 4'h0, 4'h0, B_STOP));
    tbl.push_back(mk(3'd0, 1, 4'h5, 0, 3'b001, 1, 4'h0, 4'h0, B_STOP));
    tbl.push_back(mk(3'd0, 0, 4'h5, 0, 3'b001, 1, 4'h0, 4'b1010, B_M | B_ABUS | B_LAR));
    tbl.push_back(mk(3'd0, 0, 4'h5, 0, 3'b010, 1, 4'h0, 4'h0, B_DRW | B_MBUS | F2));
    tbl.push_back(mk(3'd0, 0, 4'h7, 1, 3'b001, 1, 4'h0, 4'h0, B_PCADD));
    tbl.push_back(mk(3'd0, 0, 4'h7, 1, 3'b010, 1, 4'h0, 4'h0, F2));
    tbl.push_back(mk(3'd0, 0, 4'h7, 0, 3'b001, 1, 4'h0, 4'h0, F1));
    tbl.push_back(mk(3'd0, 0, 4'h7, 0, 3'b001, 1, 4'h0, 4'h0, F1));
`ifdef HDCTL_EXT_OPS_EN
    tbl.push_back(mk(3'd0, 0, 4'hB, 0, 3'b001, 1, 4'h0, 4'b0110, B_M | B_ABUS | B_DRW | B_LDZ | F1));
`else
    tbl.push_back(mk(3'd0, 0, 4'hB, 0, 3'b001, 1, 4'h0, 4'h0, F1));
`endif
    tbl.push_back(mk(3'd4, 0, 4'h0, 0, 3'b001, 1, 4'h0, 4'h0, F1));
    tbl.push_back(mk(3'd4, 0, 4'h0, 0, 3'b001, 0, 4'b0000, 4'h0, RWR));
    tbl.push_back(mk(3'd4, 1, 4'h0, 0, 3'b001, 0, 4'h0, 4'h0, B_STOP));
    tbl.push_back(mk(3'd4, 0, 4'h0, 0, 3'b001, 0, 4'b0101, 4'h0, RWR));
    tbl.push_back(mk(3'd4, 1, 4'h0, 0, 3'b001, 0, 4'h0, 4'h0, B_STOP));
    tbl.push_back(mk(3'd4, 0, 4'h0, 0, 3'b001, 0, 4'b1010, 4'h0, RWR));
    tbl.push_back(mk(3'd4, 1, 4'h0, 0, 3'b001, 0, 4'h0, 4'h0, B_STOP));
    tbl.push_back(mk(3'd4, 0, 4'h0, 0, 3'b001, 0, 4'b1111, 4'h0, RWR));
    tbl.push_back(mk(3'd4, 1, 4'h0, 0, 3'b001, 0, 4'h0, 4'h0, B_STOP));
    tbl.push_back(mk(3'd4, 0, 4'h0, 0, 3'b001, 0, 4'b0000, 4'h0, RWR));
    tbl.push_back(mk(3'd1, 0, 4'h0, 0, 3'b001, 0, 4'h0, 4'h0, B_STOP));
    tbl.push_back(mk(3'd1, 1, 4'h0, 0, 3'b001, 0, 4'h0, 4'h0, B_STOP));
    tbl.push_back(mk(3'd1, 0, 4'h0, 0, 3'b001, 0, 4'h0, 4'h0, B_LAR | B_SBUS | B_STOP | B_SHORT | B_SELCTL));
    tbl.push_back(mk(3'd1, 1, 4'h0, 0, 3'b001, 1, 4'h0, 4'h0, B_STOP));
    tbl.push_back(mk(3'd1, 0, 4'h0, 0, 3'b001, 1, 4'h0, 4'h0, B_MEMW | B_ARINC | B_SBUS | B_STOP | B_SHORT | B_SELCTL));
    tbl.push_back(mk(3'd2, 0, 4'h0, 0, 3'b001, 1, 4'h0, 4'h0, B_STOP));
    tbl.push_back(mk(3'd2, 1, 4'h0, 0, 3'b001, 0, 4'h0, 4'h0, B_STOP));
    tbl.push_back(mk(3'd2, 0, 4'h0, 0, 3'b001, 0, 4'h0, 4'h0, B_LAR | B_SBUS | B_STOP | B_SHORT | B_SELCTL));
    tbl.push_back(mk(3'd2, 1, 4'h0, 0, 3'b001, 1, 4'h0, 4'h0, B_STOP));
    tbl.push_back(mk(3'd2, 0, 4'h0, 0, 3'b001, 1, 4'h0, 4'h0, B_MBUS | B_ARINC | B_STOP | B_SHORT | B_SELCTL));

    do_reset();
    foreach (tbl[i]) begin
      SW = tbl[i].sw; QD = tbl[i].qd; IR = tbl[i].ir; C = tbl[i].c; Z = 1'b0;
      @(posedge T3); #1;
      check($sformatf("row%0d", i), tbl[i].w, tbl[i].st0, tbl[i].sel, tbl[i].s, tbl[i].fl);
      @(negedge T3); #1;
    end

    // STP halts after W1 with W frozen at W2; resume runs the empty W2
    do_reset();
    rstep(3'd0, 0, 4'hE, 0, 0, 0, "stp_load");
    rstep(3'd0, 1, 4'hE, 0, 0, 0, "stp_resume0");
    rstep(3'd0, 0, 4'hE, 0, 0, 0, "stp_w1");
    check("stp_halt_w2", 3'b010, 1'b1, 4'h0, 4'h0, B_STOP);
    rstep(3'd0, 1, 4'hE, 0, 0, 0, "stp_halted");
    check("stp_resume_w2", 3'b010, 1'b1, 4'h0, 4'h0, '0);

    // Reserved mode: beats run W1/W2 with all controls idle
    rstep(3'd5, 0, 4'h0, 0, 0, 0, "sw101_enter");
    check("sw101_w1", 3'b001, 1'b0, 4'h0, 4'h0, '0);
    rstep(3'd5, 0, 4'h0, 0, 0, 0, "sw101_b1");
    check("sw101_w2", 3'b010, 1'b0, 4'h0, 4'h0, '0);

    // Asynchronous clear in the middle of a W2 beat
    #2;
    CLR = 1'b1; #1;
    check("clr_async", 3'b001, 1'b0, 4'h0, 4'h0, B_LPC | B_SBUS | B_SHORT | B_STOP);
    model_reset();
    CLR = 1'b0;
    @(negedge T3); #1;
    model_next(3'd5, 1'b0, model_act(0, 0, 0, 1, 4'h0, 0, 0, 0));
    check("clr_then_mode", 3'b001, 1'b0, 4'h0, 4'h0, '0);

    // Randomized run against the model
    do_reset();
    cur_sw = 3'd0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) cur_sw = 3'($urandom_range(0, 7));
      rstep(cur_sw, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
